// File: rtl/noc_input_buffer.sv
// Per-port router input FIFO: enforces header/body/tail framing on writes and
// presents the head flit's request, id and packet length to the arbiter.
module noc_input_buffer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_flit,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  grant,
  output logic                  req,
  output logic [2:0]            flit_id,
  output logic [11:0]           length,
  output logic [DATA_WIDTH-1:0] out_flit,
  output logic                  out_valid,
  output logic [7:0]            drop_count
);

  localparam int unsigned CW  = ADDR_WIDTH + 1;
  localparam int unsigned LW  = 12;
  localparam int unsigned DCW = 8;

  localparam logic [2:0] ID_HDR  = 3'b001;
  localparam logic [2:0] ID_BODY = 3'b010;
  localparam logic [2:0] ID_TAIL = 3'b100;

  typedef enum logic {
    WAIT_HDR = 1'b0,
    IN_PKT   = 1'b1
  } wr_state_e;

  wr_state_e               state_q, state_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]           count_q, count_d;
  logic [LW-1:0]           pkt_length_q, pkt_length_d;
  logic [DATA_WIDTH-1:0]   out_flit_q, out_flit_d;
  logic                    out_valid_q, out_valid_d;
  logic [DCW-1:0]          drop_count_q, drop_count_d;

  logic                    accept_c;
  logic                    push_c;
  logic                    drop_c;
  logic                    pop_c;
  logic [2:0]              in_id_c;
  logic [DATA_WIDTH-1:0]   head_c;
  logic                    head_is_hdr_c;

  // Handshake and arbiter-facing views depend only on registered state
  assign in_ready      = (count_q != CW'(DEPTH));
  assign req           = (count_q != CW'(0));
  assign accept_c      = in_valid && in_ready;
  assign pop_c         = grant && req;
  assign in_id_c       = in_flit[2:0];
  assign head_c        = mem_q[rd_ptr_q];
  assign head_is_hdr_c = req && (head_c[2:0] == ID_HDR);

  assign flit_id    = req ? head_c[2:0] : 3'b000;
  assign length     = head_is_hdr_c ? head_c[14:3] : pkt_length_q;
  assign out_flit   = out_flit_q;
  assign out_valid  = out_valid_q;
  assign drop_count = drop_count_q;

  // Framing FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= WAIT_HDR;
    end else begin
      state_q <= state_d;
    end
  end

  // Framing FSM: decides push vs. discard for each accepted flit
  always_comb begin
    state_d = state_q;
    push_c  = 1'b0;
    drop_c  = 1'b0;
    if (accept_c) begin
      case (state_q)
        WAIT_HDR: begin
          if (in_id_c == ID_HDR) begin
            push_c  = 1'b1;
            state_d = IN_PKT;
          end else begin
            drop_c = 1'b1;
          end
        end
        IN_PKT: begin
          if (in_id_c == ID_BODY) begin
            push_c = 1'b1;
          end else if (in_id_c == ID_TAIL) begin
            push_c  = 1'b1;
            state_d = WAIT_HDR;
          end else begin
            drop_c = 1'b1;
          end
        end
        default: begin
          state_d = WAIT_HDR;
        end
      endcase
    end
  end

  // Pointer, occupancy, packet-length and output next-state
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    pkt_length_d = pkt_length_q;
    out_flit_d   = out_flit_q;
    out_valid_d  = pop_c;
    drop_count_d = drop_count_q;

    if (push_c) begin
      wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
    end
    if (pop_c) begin
      rd_ptr_d   = rd_ptr_q + ADDR_WIDTH'(1);
      out_flit_d = head_c;
      if (head_is_hdr_c) begin
        pkt_length_d = head_c[14:3];
      end
    end

    if (push_c && !pop_c) begin
      count_d = count_q + CW'(1);
    end else if (!push_c && pop_c) begin
      count_d = count_q - CW'(1);
    end

    if (drop_c && (drop_count_q != {DCW{1'b1}})) begin
      drop_count_d = drop_count_q + DCW'(1);
    end
  end

  // Control and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      pkt_length_q <= '0;
      out_flit_q   <= '0;
      out_valid_q  <= 1'b0;
      drop_count_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      pkt_length_q <= pkt_length_d;
      out_flit_q   <= out_flit_d;
      out_valid_q  <= out_valid_d;
      drop_count_q <= drop_count_d;
    end
  end

  // Storage needs no reset; occupancy alone defines which entries are live
  always_ff @(posedge clk) begin
    if (push_c && !rst) begin
      mem_q[wr_ptr_q] <= in_flit;
    end
  end

endmodule

// File: tb/tb_noc_input_buffer.sv
// Directed bench for noc_input_buffer: vector table for framing and arbiter
// views, plus hand-written sequences for full, streaming, reset and saturation.
module tb_noc_input_buffer;

  logic        clk;
  logic        rst;
  logic [31:0] in_flit;
  logic        in_valid;
  logic        in_ready;
  logic        grant;
  logic        req;
  logic [2:0]  flit_id;
  logic [11:0] length;
  logic [31:0] out_flit;
  logic        out_valid;
  logic [7:0]  drop_count;

  int total;
  int passed;

  noc_input_buffer #(.DATA_WIDTH(32), .DEPTH(8), .ADDR_WIDTH(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_flit    (in_flit),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .grant      (grant),
    .req        (req),
    .flit_id    (flit_id),
    .length     (length),
    .out_flit   (out_flit),
    .out_valid  (out_valid),
    .drop_count (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] flit;
    logic        valid;
    logic        grant;
    logic        exp_ready;
    logic        exp_req;
    logic [2:0]  exp_id;
    logic [11:0] exp_len;
    logic        exp_ov;
    logic [31:0] exp_of;
    logic [7:0]  exp_drop;
    int          exp_cnt;
  } vec_t;

  vec_t vecs[16];

  function automatic logic [31:0] mk(input logic [2:0] id, input logic [11:0] len, input int tag);
    return {17'(tag), len, id};
  endfunction

  function automatic vec_t mkv(input logic [31:0] f, input logic v, input logic g,
                               input logic rdy, input logic rq, input logic [2:0] id,
                               input logic [11:0] ln, input logic ov, input logic [31:0] of,
                               input logic [7:0] dr, input int cnt);
    vec_t r;
    r.flit = f; r.valid = v; r.grant = g; r.exp_ready = rdy; r.exp_req = rq;
    r.exp_id = id; r.exp_len = ln; r.exp_ov = ov; r.exp_of = of; r.exp_drop = dr;
    r.exp_cnt = cnt;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Drive inputs, take one clock edge, and land 1ns after it for sampling
  task automatic step(input logic [31:0] f, input logic v, input logic g, input logic r);
    in_flit = f; in_valid = v; grant = g; rst = r;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] h1, b2, b3, t4, bx, h5, h6, il, t9;

  initial begin
    total = 0;
    passed = 0;
    in_flit = '0; in_valid = 1'b0; grant = 1'b0; rst = 1'b1;

    h1 = mk(3'b001, 12'd20, 1);
    b2 = mk(3'b010, 12'hABC, 2);
    b3 = mk(3'b010, 12'hABC, 3);
    t4 = mk(3'b100, 12'h123, 4);
    bx = mk(3'b010, 12'd0, 7);
    h5 = mk(3'b001, 12'd7, 5);
    h6 = mk(3'b001, 12'd9, 6);
    il = mk(3'b111, 12'd0, 8);
    t9 = mk(3'b100, 12'd0, 9);

    //              flit v  g  rdy req id      len     ov of  drop cnt
    vecs[0]  = mkv(h1, 1, 0, 1, 1, 3'b001, 12'd20, 0, 0,  0, 1);
    vecs[1]  = mkv(b2, 1, 0, 1, 1, 3'b001, 12'd20, 0, 0,  0, 2);
    vecs[2]  = mkv(b3, 1, 0, 1, 1, 3'b001, 12'd20, 0, 0,  0, 3);
    vecs[3]  = mkv(t4, 1, 0, 1, 1, 3'b001, 12'd20, 0, 0,  0, 4);
    vecs[4]  = mkv(0,  0, 1, 1, 1, 3'b010, 12'd20, 1, h1, 0, 3);
    vecs[5]  = mkv(0,  0, 1, 1, 1, 3'b010, 12'd20, 1, b2, 0, 2);
    vecs[6]  = mkv(0,  0, 1, 1, 1, 3'b100, 12'd20, 1, b3, 0, 1);
    vecs[7]  = mkv(0,  0, 1, 1, 0, 3'b000, 12'd20, 1, t4, 0, 0);
    vecs[8]  = mkv(0,  0, 1, 1, 0, 3'b000, 12'd20, 0, t4, 0, 0);
    vecs[9]  = mkv(bx, 1, 0, 1, 0, 3'b000, 12'd20, 0, t4, 1, 0);
    vecs[10] = mkv(h5, 1, 0, 1, 1, 3'b001, 12'd7,  0, t4, 1, 1);
    vecs[11] = mkv(h6, 1, 0, 1, 1, 3'b001, 12'd7,  0, t4, 2, 1);
    vecs[12] = mkv(il, 1, 0, 1, 1, 3'b001, 12'd7,  0, t4, 3, 1);
    vecs[13] = mkv(t9, 1, 0, 1, 1, 3'b001, 12'd7,  0, t4, 3, 2);
    vecs[14] = mkv(0,  0, 1, 1, 1, 3'b100, 12'd7,  1, h5, 3, 1);
    vecs[15] = mkv(0,  0, 1, 1, 0, 3'b000, 12'd7,  1, t9, 3, 0);

    // Reset state
    step(0, 0, 0, 1);
    chk("rst.in_ready", 32'(in_ready), 1);
    chk("rst.req", 32'(req), 0);
    chk("rst.flit_id", 32'(flit_id), 0);
    chk("rst.length", 32'(length), 0);
    chk("rst.out_valid", 32'(out_valid), 0);
    chk("rst.out_flit", out_flit, 0);
    chk("rst.drop", 32'(drop_count), 0);
    rst = 1'b0;

    // Packet in/out, grant while empty, framing drops
    for (int i = 0; i < 16; i++) begin
      step(vecs[i].flit, vecs[i].valid, vecs[i].grant, 0);
      chk($sformatf("v%0d.in_ready", i), 32'(in_ready), 32'(vecs[i].exp_ready));
      chk($sformatf("v%0d.req", i), 32'(req), 32'(vecs[i].exp_req));
      chk($sformatf("v%0d.flit_id", i), 32'(flit_id), 32'(vecs[i].exp_id));
      chk($sformatf("v%0d.length", i), 32'(length), 32'(vecs[i].exp_len));
      chk($sformatf("v%0d.out_valid", i), 32'(out_valid), 32'(vecs[i].exp_ov));
      chk($sformatf("v%0d.out_flit", i), out_flit, vecs[i].exp_of);
      chk($sformatf("v%0d.drop", i), 32'(drop_count), 32'(vecs[i].exp_drop));
      chk($sformatf("v%0d.count", i), 32'(dut.count_q), 32'(vecs[i].exp_cnt));
    end

    // Fill to full, stall the 9th flit, free one slot, refill
    step(mk(3'b001, 12'd30, 10), 1, 0, 0);
    for (int i = 0; i < 7; i++) step(mk(3'b010, 12'd0, 11 + i), 1, 0, 0);
    chk("full.in_ready", 32'(in_ready), 0);
    chk("full.count", 32'(dut.count_q), 8);
    step(mk(3'b010, 12'd0, 18), 1, 0, 0);
    chk("full.stall_count", 32'(dut.count_q), 8);
    chk("full.stall_ready", 32'(in_ready), 0);
    step(mk(3'b010, 12'd0, 18), 1, 1, 0);
    chk("full.pop_ready", 32'(in_ready), 1);
    chk("full.pop_count", 32'(dut.count_q), 7);
    chk("full.pop_flit", out_flit, mk(3'b001, 12'd30, 10));
    step(mk(3'b010, 12'd0, 18), 1, 0, 0);
    chk("full.refill_count", 32'(dut.count_q), 8);
    chk("full.refill_ready", 32'(in_ready), 0);
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 1, 0);
      chk($sformatf("drain%0d.ov", i), 32'(out_valid), 1);
      chk($sformatf("drain%0d.flit", i), out_flit, mk(3'b010, 12'd0, 11 + i));
    end
    chk("drain.req", 32'(req), 0);
    chk("drain.drop", 32'(drop_count), 3);

    // Streaming push+pop at occupancy 3 across several pointer wraps
    for (int i = 0; i < 3; i++) step(mk(3'b010, 12'd0, 20 + i), 1, 0, 0);
    for (int i = 0; i < 20; i++) begin
      step(mk(3'b010, 12'd0, 23 + i), 1, 1, 0);
      chk($sformatf("stream%0d.count", i), 32'(dut.count_q), 3);
      chk($sformatf("stream%0d.flit", i), out_flit, mk(3'b010, 12'd0, 20 + i));
      chk($sformatf("stream%0d.ov", i), 32'(out_valid), 1);
    end
    step(mk(3'b100, 12'd0, 50), 1, 1, 0);
    chk("stream.tail_push_out", out_flit, mk(3'b010, 12'd0, 40));
    step(0, 0, 1, 0);
    chk("stream.end0", out_flit, mk(3'b010, 12'd0, 41));
    step(0, 0, 1, 0);
    chk("stream.end1", out_flit, mk(3'b010, 12'd0, 42));
    step(0, 0, 1, 0);
    chk("stream.end2", out_flit, mk(3'b100, 12'd0, 50));
    chk("stream.empty", 32'(req), 0);

    // Reset mid-packet with five flits stored
    step(mk(3'b001, 12'd40, 60), 1, 0, 0);
    for (int i = 0; i < 4; i++) step(mk(3'b010, 12'd0, 61 + i), 1, 0, 0);
    chk("mid.count", 32'(dut.count_q), 5);
    chk("mid.length", 32'(length), 40);
    step(mk(3'b010, 12'd0, 65), 1, 1, 1);
    chk("mid_rst.req", 32'(req), 0);
    chk("mid_rst.out_valid", 32'(out_valid), 0);
    chk("mid_rst.drop", 32'(drop_count), 0);
    chk("mid_rst.length", 32'(length), 0);
    step(mk(3'b010, 12'd0, 66), 1, 0, 0);
    chk("post_rst.drop", 32'(drop_count), 1);
    chk("post_rst.req", 32'(req), 0);

    // Drop counter saturation
    for (int i = 0; i < 254; i++) step(mk(3'b010, 12'd0, 70), 1, 0, 0);
    chk("sat.reach", 32'(drop_count), 255);
    for (int i = 0; i < 6; i++) step(mk(3'b100, 12'd0, 71), 1, 0, 0);
    chk("sat.hold", 32'(drop_count), 255);
    chk("sat.req", 32'(req), 0);

    step(0, 0, 0, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
